// File: rtl/pc_history_ctrl.sv
// Fetch-PC generator keeping a per-stage PC history and valid mask.
// Redirect priority is replay > branch > jump > sequential; a qualified redirect overrides stall.
module pc_history_ctrl #(
  parameter int XLEN = 32,
  parameter int DEPTH = 5,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int BR_STAGE = 2,
  parameter int JMP_STAGE = 1,
  localparam int DW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  br_take,
  input  logic [XLEN-1:0]       br_target,
  input  logic                  jmp_take,
  input  logic [XLEN-1:0]       jmp_target,
  input  logic                  replay_req,
  input  logic [DW-1:0]         replay_dist,
  output logic [XLEN-1:0]       pc_out,
  output logic [DEPTH*XLEN-1:0] hist_flat,
  output logic [DEPTH-2:0]      valid,
  output logic                  retire_valid,
  output logic                  redirect,
  output logic                  err
);

  logic [XLEN-1:0]  histReg  [DEPTH];
  logic [XLEN-1:0]  histNext [DEPTH];
  logic [DEPTH-1:1] validReg;
  logic [DEPTH-1:1] validNext;
  logic             redirectReg;
  logic             errReg;
  logic             errNext;

  logic             replayLegal;
  logic             replayValid;
  logic [XLEN-1:0]  replayTarget;
  logic             replayGo;
  logic             brGo;
  logic             jmpGo;
  logic             doRedirect;
  logic [XLEN-1:0]  redirectTarget;
  int               flushDepth;

  always_comb begin
    replayLegal  = (replay_dist != '0) && (replay_dist <= DW'(DEPTH - 2));
    replayValid  = 1'b0;
    replayTarget = '0;
    // Mux over the legal stages only, so an out-of-range distance never indexes the arrays.
    for (int i = 1; i <= DEPTH - 2; i++) begin
      if (replay_dist == DW'(i)) begin
        replayValid  = validReg[i];
        replayTarget = histReg[i];
      end
    end
    replayGo = replay_req && replayLegal && replayValid;
    brGo     = br_take && validReg[BR_STAGE];
    jmpGo    = jmp_take && validReg[JMP_STAGE];

    doRedirect     = 1'b1;
    redirectTarget = '0;
    flushDepth     = 0;
    if (replayGo) begin
      redirectTarget = replayTarget;
      flushDepth     = int'(replay_dist) + 1;
    end else if (brGo) begin
      redirectTarget = br_target;
      flushDepth     = BR_STAGE;
    end else if (jmpGo) begin
      redirectTarget = jmp_target;
      flushDepth     = JMP_STAGE;
    end else begin
      doRedirect = 1'b0;
    end

    errNext = errReg || (replay_req && !replayLegal);

    for (int i = 0; i < DEPTH; i++) begin
      histNext[i] = histReg[i];
    end
    validNext = validReg;
    if (doRedirect || !stall) begin
      histNext[0] = doRedirect ? redirectTarget : histReg[0] + XLEN'(4);
      for (int i = 1; i < DEPTH; i++) begin
        histNext[i] = histReg[i-1];
      end
      validNext[1] = 1'b1;
      for (int i = 2; i < DEPTH; i++) begin
        validNext[i] = validReg[i-1];
      end
      // Squash the stages younger than the resolving instruction.
      for (int i = 1; i < DEPTH; i++) begin
        if (doRedirect && i <= flushDepth) begin
          validNext[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      histReg[0] <= RESET_PC;
      for (int i = 1; i < DEPTH; i++) begin
        histReg[i] <= '0;
      end
      validReg    <= '0;
      redirectReg <= 1'b0;
      errReg      <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        histReg[i] <= histNext[i];
      end
      validReg    <= validNext;
      redirectReg <= doRedirect;
      errReg      <= errNext;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gHist
      assign hist_flat[gi*XLEN +: XLEN] = histReg[gi];
    end
    for (gi = 1; gi < DEPTH; gi++) begin : gValid
      assign valid[gi-1] = validReg[gi];
    end
  endgenerate

  assign pc_out       = histReg[0];
  assign retire_valid = validReg[DEPTH-1];
  assign redirect     = redirectReg;
  assign err          = errReg;

endmodule

// File: tb/tb_pc_history_ctrl.sv
// Scoreboard bench for pc_history_ctrl: the driver queues hand-computed expectations,
// a monitor pops one per clock edge and compares.
module tb_pc_history_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stall = 1'b0;
  logic         br_take = 1'b0;
  logic [31:0]  br_target = '0;
  logic         jmp_take = 1'b0;
  logic [31:0]  jmp_target = '0;
  logic         replay_req = 1'b0;
  logic [2:0]   replay_dist = '0;
  logic [31:0]  pc_out;
  logic [159:0] hist_flat;
  logic [3:0]   valid;
  logic         retire_valid;
  logic         redirect;
  logic         err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]  pc;
    logic [3:0]   v;
    logic         red;
    logic         err;
    logic         chkHist;
    logic [159:0] hist;
  } exp_t;

  exp_t expQ[$];

  pc_history_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_take(br_take), .br_target(br_target),
    .jmp_take(jmp_take), .jmp_target(jmp_target),
    .replay_req(replay_req), .replay_dist(replay_dist),
    .pc_out(pc_out), .hist_flat(hist_flat), .valid(valid),
    .retire_valid(retire_valid), .redirect(redirect), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic checkState(input string tag, input exp_t e);
    check({tag, ".pc_out"}, 160'(pc_out), 160'(e.pc));
    check({tag, ".valid"}, 160'(valid), 160'(e.v));
    check({tag, ".retire_valid"}, 160'(retire_valid), 160'(e.v[3]));
    check({tag, ".redirect"}, 160'(redirect), 160'(e.red));
    check({tag, ".err"}, 160'(err), 160'(e.err));
    if (e.chkHist) check({tag, ".hist_flat"}, hist_flat, e.hist);
  endtask

  // Monitor: one expectation per clock edge, sampled 1 time unit after the edge.
  initial begin
    int n = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        $display("txn %0d pc=%08h valid=%b redirect=%b err=%b", n, pc_out, valid, redirect, err);
        checkState($sformatf("txn%0d", n), e);
        n++;
      end
    end
  end

  task automatic step(input logic r, input logic st,
                      input logic br, input logic [31:0] bt,
                      input logic jm, input logic [31:0] jt,
                      input logic rr, input logic [2:0] rd,
                      input logic [31:0] ePc, input logic [3:0] eV,
                      input logic eRed, input logic eErr,
                      input logic eChk = 1'b0, input logic [159:0] eH = '0);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st;
    br_take = br; br_target = bt;
    jmp_take = jm; jmp_target = jt;
    replay_req = rr; replay_dist = rd;
    e.pc = ePc; e.v = eV; e.red = eRed; e.err = eErr; e.chkHist = eChk; e.hist = eH;
    expQ.push_back(e);
  endtask

  initial begin
    exp_t rstExp;
    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'b0000, 0, 0);
    // T1: fill; an unqualified jump on the first cycle is ignored
    step(0, 0, 0, 0, 1, 32'h999, 0, 0, 32'h4, 4'b0001, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 4'b0011, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'hC, 4'b0111, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 4'b1111, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h14, 4'b1111, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h18, 4'b1111, 0, 0);
    // T2: taken branch
    step(0, 0, 1, 32'h100, 0, 0, 0, 0, 32'h100, 4'b1100, 1, 0,
         1, {32'hC, 32'h10, 32'h14, 32'h18, 32'h100});
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 4'b1001, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h108, 4'b0011, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h10C, 4'b0111, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h110, 4'b1111, 0, 0);
    // T3: replay dist 1 beats branch and jump
    step(0, 0, 1, 32'h100, 1, 32'h200, 1, 3'd1, 32'h10C, 4'b1100, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h110, 4'b1001, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h114, 4'b0011, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h118, 4'b0111, 0, 0);
    // T4: stall freezes everything, then a jump overrides stall
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, 0, 0, 0, 0, 32'h118, 4'b0111, 0, 0,
           1, {32'h110, 32'h10C, 32'h110, 32'h114, 32'h118});
    step(0, 1, 0, 0, 1, 32'h200, 0, 0, 32'h200, 4'b1110, 1, 0,
         1, {32'h10C, 32'h110, 32'h114, 32'h118, 32'h200});
    // T5: illegal replay distances, then branch at an invalid stage
    step(0, 0, 0, 0, 0, 0, 1, 3'd0, 32'h204, 4'b1101, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 3'd4, 32'h208, 4'b1011, 0, 1);
    step(0, 0, 0, 0, 1, 32'h300, 0, 0, 32'h300, 4'b0110, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h304, 4'b1101, 0, 1);
    step(0, 0, 1, 32'h400, 0, 0, 0, 0, 32'h308, 4'b1011, 0, 1);
    // T6: wrap, then reset in a redirect cycle
    step(0, 0, 0, 0, 1, 32'hFFFFFFF8, 0, 0, 32'hFFFFFFF8, 4'b0110, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 4'b1101, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'b1011, 0, 1);
    step(0, 0, 0, 0, 1, 32'h500, 0, 0, 32'h500, 4'b0110, 1, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    rstExp.pc = 32'h0; rstExp.v = 4'b0000; rstExp.red = 1'b0; rstExp.err = 1'b0;
    rstExp.chkHist = 1'b1; rstExp.hist = '0;
    checkState("async_rst", rstExp);
    step(1, 0, 0, 0, 1, 32'h500, 0, 0, 32'h0, 4'b0000, 0, 0, 1, 160'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 4'b0001, 0, 0);
    @(posedge clk);
    #3;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
